// File: rtl/mem_arbiter.sv
// Arbitrates the shared multi-cycle memory between I-side and D-side miss handling.
// Define ARB_RR_EN for round-robin on simultaneous requests (default: D over I).
module mem_arbiter #(
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [15:0]                  d_wdata,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [15:0]                  mem_wdata,
  input  logic [15:0]                  mem_rdata,
  input  logic                         mem_data_valid,
  output logic                         fill_we,
  output logic                         fill_sel,
  output logic [$clog2(BLK_WORDS)-1:0] fill_word,
  output logic [15:0]                  fill_data,
  output logic                         i_done,
  output logic                         d_done,
  output logic                         busy
);

  localparam int WB = $clog2(BLK_WORDS);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2*BLK_WORDS-1);
  localparam logic [ADDR_W-1:0] HW_MASK  = ~ADDR_W'(1);

  if (MEM_LAT < 1 || BLK_WORDS < 2) begin : g_bad_cfg
    $error("mem_arbiter: unsupported MEM_LAT/BLK_WORDS");
  end

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t            state;
  logic              owner;
  logic [ADDR_W-1:0] base;
  logic [WB:0]       issue_cnt;
  logic [WB-1:0]     ret_cnt;
  logic              grant_d;
  logic              grant_i;
  logic              last_ret;
  logic [ADDR_W-1:0] a_sel;
`ifdef ARB_RR_EN
  logic              last_grant;
`endif

  always_comb begin
`ifdef ARB_RR_EN
    // last_grant: 1 = D-side won the previous grant
    grant_d = d_req && (!i_req || !last_grant);
`else
    grant_d = d_req;
`endif
    grant_i = i_req && !grant_d;
    a_sel   = grant_d ? d_addr : i_addr;
  end

  assign fill_we   = (state == FILL) && mem_data_valid;
  assign fill_sel  = fill_we && owner;
  assign fill_word = fill_we ? ret_cnt : '0;
  assign fill_data = fill_we ? mem_rdata : '0;
  assign last_ret  = fill_we && (ret_cnt == WB'(BLK_WORDS-1));
  assign i_done    = last_ret && !owner;
  assign d_done    = (last_ret && owner) || (state == WRITE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      base      <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_wdata <= '0;
          ret_cnt   <= '0;
          if (grant_d && d_wr) begin
            state     <= WRITE;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= a_sel & HW_MASK;
            mem_wdata <= d_wdata;
          end else if (grant_d || grant_i) begin
            state     <= FILL;
            owner     <= grant_d;
            base      <= a_sel & BLK_MASK;
            mem_en    <= 1'b1;
            mem_addr  <= a_sel & BLK_MASK;
            issue_cnt <= (WB+1)'(1);
          end
`ifdef ARB_RR_EN
          if (grant_d || grant_i) last_grant <= grant_d;
`endif
        end
        FILL: begin
          // low address bits come from the counter, so no carry leaves the block
          if (issue_cnt != (WB+1)'(BLK_WORDS)) begin
            mem_addr  <= base | ADDR_W'({issue_cnt[WB-1:0], 1'b0});
            issue_cnt <= issue_cnt + 1'b1;
          end else begin
            mem_en <= 1'b0;
          end
          if (fill_we) ret_cnt <= ret_cnt + 1'b1;
          if (last_ret) begin
            state  <= IDLE;
            mem_en <= 1'b0;
          end
        end
        WRITE: begin
          state     <= IDLE;
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_wdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model.
// Read data returned by the model is the issued address XOR 16'hA5A5.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_data_valid;
  logic        fill_we;
  logic        fill_sel;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done;
  logic        d_done;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  logic        stray_v = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_data_valid(mem_data_valid),
    .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word),
    .fill_data(fill_data), .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  // memory model: a read issued in cycle n returns in cycle n+4
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en && !mem_wr};
    pa[0] <= mem_addr;
    for (int k = 1; k < 4; k++) pa[k] <= pa[k-1];
  end

  assign mem_data_valid = pv[3] | stray_v;
  assign mem_rdata = stray_v ? 16'h1111 : (pa[3] ^ 16'hA5A5);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 32'(mem_en), 0);
    chk({tag, "_wr"}, 32'(mem_wr), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_we"}, 32'(fill_we), 0);
    chk({tag, "_sel"}, 32'(fill_sel), 0);
    chk({tag, "_word"}, 32'(fill_word), 0);
    chk({tag, "_data"}, 32'(fill_data), 0);
    chk({tag, "_idone"}, 32'(i_done), 0);
    chk({tag, "_ddone"}, 32'(d_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Call with the request raised just before the grant edge.
  task automatic fill_check(input logic [15:0] base, input logic sel);
    logic [15:0] ea;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk("f_en", 32'(mem_en), 32'(c <= 8));
      if (c <= 8) begin
        ea = base + 16'(2 * (c - 1));
        chk("f_addr", 32'(mem_addr), 32'(ea));
        chk("f_rd", 32'(mem_wr), 0);
      end
      chk("f_we", 32'(fill_we), 32'(c >= 5 && c <= 12));
      if (c >= 5 && c <= 12) begin
        ea = base + 16'(2 * (c - 5));
        chk("f_word", 32'(fill_word), 32'(c - 5));
        chk("f_data", 32'(fill_data), 32'(ea ^ 16'hA5A5));
        chk("f_sel", 32'(fill_sel), 32'(sel));
      end
      chk("f_idone", 32'(i_done), 32'(c == 12 && !sel));
      chk("f_ddone", 32'(d_done), 32'(c == 12 && sel));
      chk("f_busy", 32'(busy), 32'(c <= 12));
      if (c == 12) begin
        if (sel) d_req = 1'b0;
        else i_req = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    i_req = 1'b1; i_addr = 16'h0036;
    fill_check(16'h0030, 1'b0);

    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2008;
    i_req = 1'b1; i_addr = 16'h0456;
    fill_check(16'h2000, 1'b1);
    fill_check(16'h0450, 1'b0);

    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h1235; d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("w_en", 32'(mem_en), 1);
    chk("w_wr", 32'(mem_wr), 1);
    chk("w_addr", 32'(mem_addr), 32'h1234);
    chk("w_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("w_ddone", 32'(d_done), 1);
    chk("w_we", 32'(fill_we), 0);
    chk("w_busy", 32'(busy), 1);
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    chk("w2_en", 32'(mem_en), 0);
    chk("w2_wdata", 32'(mem_wdata), 0);
    chk("w2_ddone", 32'(d_done), 0);
    chk("w2_busy", 32'(busy), 0);

    d_req = 1'b1; d_addr = 16'h3010;
    i_req = 1'b1; i_addr = 16'h0788;
`ifdef ARB_RR_EN
    fill_check(16'h0780, 1'b0);
    fill_check(16'h3010, 1'b1);
`else
    fill_check(16'h3010, 1'b1);
    fill_check(16'h0780, 1'b0);
`endif

    d_req = 1'b1; d_addr = 16'hFFF4;
    fill_check(16'hFFF0, 1'b1);

    i_req = 1'b1; i_addr = 16'h0104;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("r_en", 32'(mem_en), 1);
      chk("r_addr", 32'(mem_addr), 32'(16'h0100 + 16'(2 * (c - 1))));
    end
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rmid");
    rst = 1'b0; i_req = 1'b0;
    for (int c = 8; c <= 13; c++) begin
      @(negedge clk);
      chk("late_we", 32'(fill_we), 0);
      chk("late_idone", 32'(i_done), 0);
      chk("late_busy", 32'(busy), 0);
    end

    stray_v = 1'b1;
    @(negedge clk);
    chk("stray_we", 32'(fill_we), 0);
    chk("stray_busy", 32'(busy), 0);
    stray_v = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single unified multi-cycle memory between instruction-side and data-side cache miss handling.
- Grants one requester at a time.
- Sequences an 8-word block fill with pipelined address issue, or a single-word data write.
- Steers returned words to the owning cache's fill port, then pulses a done strobe.
- Sits between the I-cache/D-cache miss logic and the memory4c instance in the cpu top level.

Parameters:
- MEM_LAT, 4: memory read latency in cycles, from address issue to mem_data_valid.
- BLK_WORDS, 8: 16-bit words per cache block; block size is 16 bytes.
- ADDR_W, 16: byte address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  1  I-side miss request; held high until i_done.
- i_addr  input  16  I-side miss byte address; any byte within the block.
- d_req  input  1  D-side request (fill or write); held high until d_done.
- d_wr  input  1  with d_req: 1 = single-word write, 0 = block fill.
- d_addr  input  16  D-side byte address.
- d_wdata  input  16  D-side write data.
- mem_en  output  1  memory access enable.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  16  memory byte address.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  memory read data.
- mem_data_valid  input  1  mem_rdata valid this cycle.
- fill_we  output  1  write a returned word into the selected cache.
- fill_sel  output  1  0 = I-cache, 1 = D-cache; valid while fill_we=1.
- fill_word  output  3  word index within block (mem byte address bits [3:1]).
- fill_data  output  16  returned word (mem_rdata passthrough).
- i_done  output  1  one-cycle pulse: I-side fill complete.
- d_done  output  1  one-cycle pulse: D-side fill or write complete.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: every output is 0; state goes to IDLE; issue and return counters clear. Reset mid-operation aborts the transfer with no done pulse. A mem_data_valid arriving after reset is ignored.
- States: IDLE, FILL, WRITE.
- IDLE arbitration, sampled each clock edge:
  - d_req has fixed priority over i_req.
  - Granted fill -> FILL; owner is latched.
  - d_req with d_wr=1 -> WRITE.
  - Block base is latched as {addr[15:4], 4'h0}; d_wdata is latched for writes.
- FILL issue:
  - Issue cycles 1..BLK_WORDS after grant.
  - Each cycle: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt runs 0..7.
  - mem_en=0 once all 8 words are issued.
- FILL return:
  - Each mem_data_valid: fill_we=1, fill_sel=owner, fill_word=ret_cnt, fill_data=mem_rdata; ret_cnt increments.
  - Word k returns in cycle 1+k+MEM_LAT.
  - On the 8th return (cycle 8+MEM_LAT = 12 at defaults), the owner's done pulses in the same cycle as the last fill_we. Next state is IDLE.
  - Earliest next grant is sampled at the following edge.
- mem_data_valid in IDLE or WRITE: ignored; fill_we stays 0.
- WRITE:
  - One cycle: mem_en=1, mem_wr=1, mem_addr=latched d_addr with bit 0 cleared, mem_wdata=latched data.
  - d_done pulses in the same cycle; next state is IDLE.
- Requests are not re-sampled while busy. A request dropped before done is a protocol error; the transfer completes anyway.
- Requester handling after done: a requester still high in the cycle after its done is treated as a new request. Cache FSMs deassert req on done.
- Address arithmetic: 16-bit, no carry out of bits [3:0]; a block never crosses its 16-byte boundary.
- mem_wdata is 0 whenever mem_wr=0.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin on simultaneous i_req and d_req.
  - A last_grant flop (reset value: I-side) is updated on each grant.
  - The requester not last granted wins a tie.
  - A lone requester is always granted.
- Undefined: fixed D-over-I priority as described in Behaviour; no last_grant flop.

Test Plan:
- Reset, then i_req=1, i_addr=16'h0036 -> mem_addr 0x0030,0x0032..0x003E in cycles 1-8. fill_sel=0, fill_word 0..7 in cycles 5-12. i_done pulses in cycle 12; busy=0 in cycle 13.
- d_req=1, d_wr=1, d_addr=16'h1235, d_wdata=16'hBEEF -> exactly one cycle of mem_en=1, mem_wr=1, mem_addr=0x1234, mem_wdata=0xBEEF. d_done pulses in the same cycle; no fill_we.
- i_req and d_req (fill) raised in the same cycle -> D fill serviced first (fill_sel=1, d_done). The I fill follows; its first issue comes exactly 2 cycles after d_done. Under ARB_RR_EN, a second simultaneous pair grants I first.
- Block at 16'hFFF0 -> addresses 0xFFF0..0xFFFE issued; no wrap into 0x0000.
- rst asserted in cycle 6 of a fill -> all outputs 0 in the next cycle. Late mem_data_valid pulses produce no fill_we and no done.
- Stray mem_data_valid while IDLE with mem_rdata=16'h1111 -> fill_we stays 0 and busy stays 0.
